// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths, state enum and word indices for the systolic result path
package systolic_pkg;

  localparam int ARRAY_RES_W = 17;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_OUT_W   = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } acc_state_t;

  localparam logic [1:0] IDX_C11 = 2'd0;
  localparam logic [1:0] IDX_C12 = 2'd1;
  localparam logic [1:0] IDX_C21 = 2'd2;
  localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/sat_clip.sv
// rtl/sat_clip.sv - combinational signed clip from IN_W to OUT_W with a clipped flag
module sat_clip #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clipped
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout    = din[OUT_W-1:0];
    clipped = 1'b0;
    if (din > MAX_V) begin
      dout    = MAX_V[OUT_W-1:0];
      clipped = 1'b1;
    end else if (din < MIN_V) begin
      dout    = MIN_V[OUT_W-1:0];
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_result_accumulator.sv
// rtl/systolic_result_accumulator.sv - accumulates 2x2 tile results over K and streams saturated words
module systolic_result_accumulator
  import systolic_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [ARRAY_RES_W-1:0] c11,
  input  logic signed [ARRAY_RES_W-1:0] c12,
  input  logic signed [ARRAY_RES_W-1:0] c21,
  input  logic signed [ARRAY_RES_W-1:0] c22,
  input  logic                          tile_done,
  input  logic                          last_tile,
  output logic                          acc_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic [1:0]                    out_idx,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          overrun
);

  acc_state_t state, state_nxt;
  logic [1:0] idx, idx_nxt;

  logic signed [ARRAY_RES_W-1:0] c_in [4];
  logic signed [ACC_W-1:0]       acc [4];
  logic signed [ACC_W-1:0]       sum [4];
  logic signed [OUT_W-1:0]       clip [4];
  logic [3:0]                    clip_flag;
  logic signed [OUT_W-1:0]       buf_data [4];
  logic [3:0]                    buf_flag;
  logic                          accept;

  assign c_in[0] = c11;
  assign c_in[1] = c12;
  assign c_in[2] = c21;
  assign c_in[3] = c22;

  // Sum wraps at ACC_W; only the value loaded into the output buffer is clipped.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign sum[g] = acc[g] + {{(ACC_W-ARRAY_RES_W){c_in[g][ARRAY_RES_W-1]}}, c_in[g]};
    sat_clip #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_clip (
      .din     (sum[g]),
      .dout    (clip[g]),
      .clipped (clip_flag[g])
    );
  end

  assign accept = tile_done && (state == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      idx   <= IDX_C11;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_ACCUM: begin
        if (tile_done && last_tile) begin
          state_nxt = ST_DRAIN;
          idx_nxt   = IDX_C11;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx == IDX_C22) begin
            state_nxt = ST_ACCUM;
            idx_nxt   = IDX_C11;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_ACCUM;
        idx_nxt   = IDX_C11;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc[i]      <= '0;
        buf_data[i] <= '0;
      end
      buf_flag <= '0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          if (last_tile) begin
            buf_data[i] <= clip[i];
            acc[i]      <= '0;
          end else begin
            acc[i] <= sum[i];
          end
        end
        if (last_tile) buf_flag <= clip_flag;
      end
      if (tile_done && (state != ST_ACCUM)) overrun <= 1'b1;
    end
  end

  assign acc_ready = (state == ST_ACCUM);
  assign out_valid = (state == ST_DRAIN);
  assign out_idx   = idx;
  assign out_data  = buf_data[idx];
  assign out_sat   = buf_flag[idx];
  assign out_last  = out_valid && (idx == IDX_C22);

endmodule

// File: tb/tb_systolic_result_accumulator.sv
// tb/tb_systolic_result_accumulator.sv - directed self-checking bench for systolic_result_accumulator
module tb_systolic_result_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [16:0] c11, c12, c21, c22;
  logic               tile_done, last_tile;
  logic               acc_ready, out_valid, out_ready;
  logic signed [15:0] out_data;
  logic [1:0]         out_idx;
  logic               out_last, out_sat, overrun;

  int vectors = 0;
  int miscompares = 0;

  systolic_result_accumulator #(.ACC_W(24), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22),
    .tile_done (tile_done),
    .last_tile (last_tile),
    .acc_ready (acc_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tile(input int a, input int b, input int c, input int d, input logic last);
    c11 = 17'(a); c12 = 17'(b); c21 = 17'(c); c22 = 17'(d);
    tile_done = 1'b1;
    last_tile = last;
    step();
    tile_done = 1'b0;
    last_tile = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    do_tile(123, 123, 123, 123, 1'b1);
    rst = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || acc_ready !== 1'b1 || out_data !== 16'sd0 || out_idx !== 2'd0 ||
        out_last !== 1'b0 || out_sat !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b ready=%b data=%0d idx=%0d last=%b sat=%b ovr=%b want 0 1 0 0 0 0 0",
               out_valid, acc_ready, out_data, out_idx, out_last, out_sat, overrun);
    end
    last_tile = 1'b1;
    step();
    last_tile = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || acc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL last_without_done: valid=%b ready=%b want 0 1", out_valid, acc_ready);
    end
  endtask

  task automatic test_single_tile();
    logic signed [15:0] exp_d [4];
    logic               exp_s [4];
    exp_d = '{16'sd100, -16'sd5, 16'sd0, -16'sd32768};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    do_tile(100, -5, 0, -65536, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== exp_d[k] ||
          out_sat !== exp_s[k] || out_last !== (k == 3) || acc_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL single_word%0d: valid=%b idx=%0d data=%0d sat=%b last=%b ready=%b want 1 %0d %0d %b %b 0",
                 k, out_valid, out_idx, out_data, out_sat, out_last, acc_ready, k, exp_d[k], exp_s[k], k == 3);
      end
      step();
    end
    vectors++;
    if (acc_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: ready=%b valid=%b want 1 0", acc_ready, out_valid);
    end
  endtask

  task automatic test_multi_tile();
    out_ready = 1'b1;
    do_tile(1000, 1000, 1000, 1000, 1'b0);
    do_tile(2000, 2000, 2000, 2000, 1'b0);
    do_tile(-500, -500, -500, -500, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== 16'sd2500 || out_sat !== 1'b0) begin
        miscompares++;
        $display("FAIL multi_word%0d: valid=%b idx=%0d data=%0d sat=%b want 1 %0d 2500 0",
                 k, out_valid, out_idx, out_data, out_sat, k);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] exp_d [4];
    logic               exp_s [4];
    exp_d = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
    exp_s = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    do_tile(65535, 0, 0, 0, 1'b0);
    do_tile(65535, 0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== exp_d[k] || out_sat !== exp_s[k]) begin
        miscompares++;
        $display("FAIL sat_word%0d: valid=%b idx=%0d data=%0d sat=%b want 1 %0d %0d %b",
                 k, out_valid, out_idx, out_data, out_sat, k, exp_d[k], exp_s[k]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] exp_d [4];
    int cnt;
    exp_d = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    cnt = 0;
    out_ready = 1'b0;
    do_tile(10, 20, 30, 40, 1'b1);
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 16'sd10) begin
        miscompares++;
        $display("FAIL bp_stall%0d: valid=%b idx=%0d data=%0d want 1 0 10", s, out_valid, out_idx, out_data);
      end
      step();
    end
    for (int cyc = 0; cyc < 40 && cnt < 4; cyc++) begin
      out_ready = (cyc % 2 == 0);
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(cnt) || out_data !== exp_d[cnt] || acc_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: valid=%b idx=%0d data=%0d ready=%b want 1 %0d %0d 0",
                 cyc, out_valid, out_idx, out_data, acc_ready, cnt, exp_d[cnt]);
      end
      if (out_ready) cnt++;
      step();
    end
    out_ready = 1'b0;
    vectors++;
    if (cnt !== 4 || acc_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end: transfers=%0d ready=%b valid=%b want 4 1 0", cnt, acc_ready, out_valid);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    do_tile(1, 2, 3, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_idx !== 2'(k) || out_data !== 16'(k + 1) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL ovr_word%0d: valid=%b idx=%0d data=%0d want 1 %0d %0d", k, out_valid, out_idx, out_data, k, k + 1);
      end
      if (k == 1 || k == 3) begin
        c11 = 17'sd500; c12 = 17'sd500; c21 = 17'sd500; c22 = 17'sd500;
        tile_done = 1'b1;
        last_tile = (k == 1);
      end
      step();
      tile_done = 1'b0;
      last_tile = 1'b0;
    end
    vectors++;
    if (overrun !== 1'b1 || acc_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_flag: ovr=%b ready=%b valid=%b want 1 1 0", overrun, acc_ready, out_valid);
    end
    do_tile(5, 5, 5, 5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'sd5 || overrun !== 1'b1) begin
        miscompares++;
        $display("FAIL ovr_next%0d: valid=%b data=%0d ovr=%b want 1 5 1", k, out_valid, out_data, overrun);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    do_tile(9, 9, 9, 9, 1'b1);
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL rstmid_pre: valid=%b idx=%0d want 1 2", out_valid, out_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || acc_ready !== 1'b1 || out_idx !== 2'd0 || out_data !== 16'sd0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_after: valid=%b ready=%b idx=%0d data=%0d ovr=%b want 0 1 0 0 0",
               out_valid, acc_ready, out_idx, out_data, overrun);
    end
    do_tile(7, 7, 7, 7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== 16'sd7 || out_last !== (k == 3)) begin
        miscompares++;
        $display("FAIL rstmid_word%0d: valid=%b idx=%0d data=%0d last=%b want 1 %0d 7 %b",
                 k, out_valid, out_idx, out_data, out_last, k, k == 3);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    tile_done = 1'b0;
    last_tile = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
